// File: rtl/cordic_multimode.sv
// Iterative multimode CORDIC: rotation (x,y by theta) and vectoring (magnitude, atan2),
// one micro-rotation per clock, full +/-pi range via quadrant pre-rotation.
module cordic_multimode #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int AFRAC = 13,
  parameter int ITER  = 14,
  parameter int GUARD = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] theta_in,
  input  logic             mode,
  input  logic             operands_val,
  output logic             in_ready,
  input  logic             ack,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             out_valid,
  output logic [1:0]       state
);

  localparam int XW = WIDTH + GUARD + 2;
  localparam int ZW = WIDTH + GUARD + 1;
  localparam int ZF = AFRAC + GUARD;
  localparam int RW = XW + 1 - GUARD;
  localparam int CW = $clog2(ITER + 1);

  if (ITER < 1 || ITER > WIDTH || FRAC >= WIDTH || GUARD < 1 || ZF > 29) begin : g_param_check
    $error("cordic_multimode: unsupported parameter set");
  end

  // Angle constants are held at 2^-30 resolution and rounded to the internal z format.
  function automatic logic signed [ZW-1:0] atan_q(input int unsigned i);
    logic [63:0] t;
    case (i)
      0:       t = 64'd843314857;
      1:       t = 64'd497837829;
      2:       t = 64'd263043837;
      3:       t = 64'd133525159;
      4:       t = 64'd67021687;
      5:       t = 64'd33543516;
      6:       t = 64'd16775851;
      7:       t = 64'd8388437;
      8:       t = 64'd4194283;
      9:       t = 64'd2097149;
      default: t = (i < 31) ? (64'd1 << (30 - i)) : '0;
    endcase
    return ZW'((t + (64'd1 << (29 - ZF))) >> (30 - ZF));
  endfunction

  localparam logic [63:0] HALF_PI_R = (64'd1686629713 + (64'd1 << (29 - ZF))) >> (30 - ZF);
  localparam logic signed [ZW-1:0] HALF_PI = ZW'(HALF_PI_R);
  localparam logic [XW:0]   RND_X = (XW + 1)'(1) << (GUARD - 1);
  localparam logic [ZW-1:0] RND_Z = ZW'(1) << (GUARD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic signed [XW-1:0] x_q, y_q, x_ext, y_ext, x0, y0, x_nx, y_nx, xs, ys;
  logic signed [ZW-1:0] z_q, z_in, z0, z_nx, a_i;
  logic [CW-1:0]        cnt_q;
  logic                 mode_q, accept, d_pos, calc_last;
  logic [XW:0]          x_sum, y_sum;
  logic [ZW-1:0]        z_sum;
  logic                 unused_bits;

  always_ff @(posedge Clk) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign calc_last = (cnt_q == CW'(ITER));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (operands_val) state_d = CALC;
      end
      CALC: if (calc_last) state_d = DONE;
      DONE: begin
        in_ready = ack;
        if (ack) state_d = operands_val ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = operands_val & in_ready;
  assign out_valid = (state_q == DONE);
  assign state     = state_q;

  assign x_ext = {{2{x_in[WIDTH-1]}}, x_in, {GUARD{1'b0}}};
  assign y_ext = {{2{y_in[WIDTH-1]}}, y_in, {GUARD{1'b0}}};
  assign z_in  = {theta_in[WIDTH-1], theta_in, {GUARD{1'b0}}};

  // Quadrant pre-rotation by +/-pi/2 keeps the remaining angle inside CORDIC convergence.
  always_comb begin
    x0 = x_ext;
    y0 = y_ext;
    z0 = z_in;
    if (!mode) begin
      if (z_in > HALF_PI) begin
        x0 = -y_ext;  y0 = x_ext;   z0 = z_in - HALF_PI;
      end else if (z_in < -HALF_PI) begin
        x0 = y_ext;   y0 = -x_ext;  z0 = z_in + HALF_PI;
      end
    end else begin
      z0 = '0;
      if (x_in[WIDTH-1]) begin
        if (!y_in[WIDTH-1]) begin
          x0 = y_ext;   y0 = -x_ext;  z0 = HALF_PI;
        end else begin
          x0 = -y_ext;  y0 = x_ext;   z0 = -HALF_PI;
        end
      end
    end
  end

  always_comb begin
    xs    = x_q >>> cnt_q;
    ys    = y_q >>> cnt_q;
    a_i   = atan_q(32'(cnt_q));
    d_pos = mode_q ? y_q[XW-1] : ~z_q[ZW-1];
    if (d_pos) begin
      x_nx = x_q - ys;  y_nx = y_q + xs;  z_nx = z_q - a_i;
    end else begin
      x_nx = x_q + ys;  y_nx = y_q - xs;  z_nx = z_q + a_i;
    end
  end

  function automatic logic [WIDTH-1:0] sat(input logic [RW-1:0] v);
    if ((&v[RW-1:WIDTH-1]) || !(|v[RW-1:WIDTH-1])) return v[WIDTH-1:0];
    return v[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign x_sum       = {x_q[XW-1], x_q} + RND_X;
  assign y_sum       = {y_q[XW-1], y_q} + RND_X;
  assign z_sum       = z_q + RND_Z;
  assign unused_bits = ^{x_sum[GUARD-1:0], y_sum[GUARD-1:0], z_sum[ZW-1], z_sum[GUARD-1:0]};

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else if (accept) begin
      x_q    <= x0;
      y_q    <= y0;
      z_q    <= z0;
      mode_q <= mode;
      cnt_q  <= '0;
    end else if (state_q == CALC) begin
      if (calc_last) begin
        x_out <= sat(x_sum[XW:GUARD]);
        y_out <= sat(y_sum[XW:GUARD]);
        z_out <= z_sum[WIDTH+GUARD-1:GUARD];
      end else begin
        x_q   <= x_nx;
        y_q   <= y_nx;
        z_q   <= z_nx;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule
